// File: rtl/oled_text_seq_if.sv
// Command word bus between the glyph sequencer and the IIC byte writer.
// One 24-bit word {slave addr, control byte, payload} moves on valid & ready.
interface oled_text_seq_if;
    logic        cmd_valid;
    logic [23:0] cmd_data;
    logic        cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/oled_text_seq.sv
// Glyph-string renderer for the SSD1306-class OLED path.
// Walks a descriptor list and, for every on-screen glyph, emits for each of
// its two pages a page command, two column commands and W font bytes
// (W = 8 or 16), one IIC word at a time. A glyph that would run past
// column 127 or start on page 7 is skipped and flagged in clip_err.
module oled_text_seq #(
    parameter int           NUM_GLYPHS = 16,
    parameter int           IDX_W      = 4,
    parameter int           CODE_W     = 6,
    parameter logic [7:0]   OLED_ADDR  = 8'h78
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [IDX_W:0]    num_glyphs,
    output logic [IDX_W-1:0]  desc_idx,
    input  logic [CODE_W-1:0] desc_code,
    input  logic              desc_wide,
    input  logic              desc_inv,
    input  logic [6:0]        desc_x,
    input  logic [2:0]        desc_y,
    output logic [CODE_W-1:0] rom_code,
    output logic              rom_row,
    output logic [3:0]        rom_col,
    input  logic [7:0]        rom_data,
    oled_text_seq_if.master   cmd,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              clip_err
);

    typedef enum logic [2:0] {
        IDLE, FETCH, PAGE, COLL, COLH, RDROM, DATA, NEXT
    } state_t;

    localparam logic [IDX_W:0] MAX_N = (IDX_W+1)'(NUM_GLYPHS);

    state_t              state;
    logic [IDX_W:0]      n_r;
    logic [CODE_W-1:0]   code_r;
    logic                wide_r;
    logic                inv_r;
    logic [6:0]          x_r;
    logic [2:0]          y_r;
    logic                row_r;
    logic                valid_r;
    logic [23:0]         cmd_r;
    logic                abort_pend;

    logic [7:0]          span_end;
    logic                clip;
    logic [3:0]          last_col;
    logic                xfer;
    logic                last_glyph;

    assign span_end   = {1'b0, desc_x} + (desc_wide ? 8'd16 : 8'd8);
    assign clip       = (span_end > 8'd128) || (desc_y == 3'd7);
    assign last_col   = wide_r ? 4'd15 : 4'd7;
    assign xfer       = valid_r & cmd.cmd_ready;
    assign last_glyph = (n_r == '0) || ({1'b0, desc_idx} == (n_r - 1'b1));

    // The font byte is taken straight from the ROM while in DATA; the ROM
    // address is frozen for the whole DATA state so the word cannot change
    // while it is waiting for the writer.
    assign cmd.cmd_valid = valid_r;
    assign cmd.cmd_data  = (state == DATA) ? {OLED_ADDR, 8'h40, rom_data ^ {8{inv_r}}}
                                           : cmd_r;

    // Sequencer: list walk, command/data word generation, abort at word boundaries.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            n_r        <= '0;
            code_r     <= '0;
            wide_r     <= 1'b0;
            inv_r      <= 1'b0;
            x_r        <= '0;
            y_r        <= '0;
            row_r      <= 1'b0;
            valid_r    <= 1'b0;
            cmd_r      <= '0;
            abort_pend <= 1'b0;
            desc_idx   <= '0;
            rom_code   <= '0;
            rom_row    <= 1'b0;
            rom_col    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            clip_err   <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    n_r        <= (num_glyphs > MAX_N) ? MAX_N : num_glyphs;
                    desc_idx   <= '0;
                    row_r      <= 1'b0;
                    busy       <= 1'b1;
                    clip_err   <= 1'b0;
                    abort_pend <= 1'b0;
                    state      <= (num_glyphs == '0) ? NEXT : FETCH;
                end
            end else if ((abort || abort_pend) && (!valid_r || xfer)) begin
                state      <= IDLE;
                valid_r    <= 1'b0;
                busy       <= 1'b0;
                aborted    <= 1'b1;
                desc_idx   <= '0;
                row_r      <= 1'b0;
                abort_pend <= 1'b0;
            end else begin
                if (abort) begin
                    abort_pend <= 1'b1;
                end
                unique case (state)
                    FETCH: begin
                        code_r <= desc_code;
                        wide_r <= desc_wide;
                        inv_r  <= desc_inv;
                        x_r    <= desc_x;
                        y_r    <= desc_y;
                        if (clip) begin
                            clip_err <= 1'b1;
                            state    <= NEXT;
                        end else begin
                            valid_r <= 1'b1;
                            cmd_r   <= {OLED_ADDR, 8'h00, 8'hB0 | {5'b0, desc_y}};
                            state   <= PAGE;
                        end
                    end
                    PAGE: begin
                        if (xfer) begin
                            cmd_r <= {OLED_ADDR, 8'h00, 8'h00 | {4'b0, x_r[3:0]}};
                            state <= COLL;
                        end
                    end
                    COLL: begin
                        if (xfer) begin
                            cmd_r <= {OLED_ADDR, 8'h00, 8'h10 | {5'b0, x_r[6:4]}};
                            state <= COLH;
                        end
                    end
                    COLH: begin
                        if (xfer) begin
                            valid_r  <= 1'b0;
                            rom_code <= code_r;
                            rom_row  <= row_r;
                            rom_col  <= '0;
                            state    <= RDROM;
                        end
                    end
                    RDROM: begin
                        valid_r <= 1'b1;
                        state   <= DATA;
                    end
                    DATA: begin
                        if (xfer) begin
                            valid_r <= 1'b0;
                            if (rom_col < last_col) begin
                                rom_col <= rom_col + 4'd1;
                                state   <= RDROM;
                            end else if (!row_r) begin
                                row_r   <= 1'b1;
                                valid_r <= 1'b1;
                                cmd_r   <= {OLED_ADDR, 8'h00, 8'hB0 | {5'b0, y_r + 3'd1}};
                                state   <= PAGE;
                            end else begin
                                state <= NEXT;
                            end
                        end
                    end
                    NEXT: begin
                        row_r <= 1'b0;
                        if (last_glyph) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            desc_idx <= desc_idx + 1'b1;
                            state    <= FETCH;
                        end
                    end
                    IDLE:    ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oled_text_seq.sv
// Scoreboard bench for oled_text_seq: a list-level model queues the expected
// IIC words, a monitor pops and compares every word the writer accepts.
module tb_oled_text_seq;

    localparam int IDX_W  = 4;
    localparam int CODE_W = 6;

    logic              sys_clk = 1'b0;
    logic              rst     = 1'b1;
    logic              start   = 1'b0;
    logic              abort   = 1'b0;
    logic [IDX_W:0]    num_glyphs = '0;
    logic [IDX_W-1:0]  desc_idx;
    logic [CODE_W-1:0] desc_code;
    logic              desc_wide;
    logic              desc_inv;
    logic [6:0]        desc_x;
    logic [2:0]        desc_y;
    logic [CODE_W-1:0] rom_code;
    logic              rom_row;
    logic [3:0]        rom_col;
    logic [7:0]        rom_data = 8'h00;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              clip_err;

    oled_text_seq_if cmd_if ();

    oled_text_seq #(
        .NUM_GLYPHS (16),
        .IDX_W      (IDX_W),
        .CODE_W     (CODE_W),
        .OLED_ADDR  (8'h78)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .num_glyphs (num_glyphs),
        .desc_idx   (desc_idx),
        .desc_code  (desc_code),
        .desc_wide  (desc_wide),
        .desc_inv   (desc_inv),
        .desc_x     (desc_x),
        .desc_y     (desc_y),
        .rom_code   (rom_code),
        .rom_row    (rom_row),
        .rom_col    (rom_col),
        .rom_data   (rom_data),
        .cmd        (cmd_if.master),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .clip_err   (clip_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Descriptor table seen by the DUT
    logic [CODE_W-1:0] t_code [16];
    logic              t_wide [16];
    logic              t_inv  [16];
    logic [6:0]        t_x    [16];
    logic [2:0]        t_y    [16];

    assign desc_code = t_code[desc_idx];
    assign desc_wide = t_wide[desc_idx];
    assign desc_inv  = t_inv[desc_idx];
    assign desc_x    = t_x[desc_idx];
    assign desc_y    = t_y[desc_idx];

    // Font contents: an arbitrary byte pattern that differs per code/row/column
    function automatic logic [7:0] font(input logic [5:0] c, input logic r, input logic [3:0] col);
        logic [7:0] v;
        v = 8'(c) * 8'd29 + 8'(col) * 8'd17 + (r ? 8'd101 : 8'd3);
        return v ^ {c[1:0], col, r, 1'b1};
    endfunction

    // Synchronous font ROM: one cycle from address to data
    always @(posedge sys_clk) rom_data <= font(rom_code, rom_row, rom_col);

    int          checks = 0;
    int          failures = 0;
    int          xfer_count = 0;
    int          done_cnt = 0;
    int          aborted_cnt = 0;
    int          busy_cycles = 0;
    int          stall_cycles = 0;
    int          stall_cnt = 0;
    int          ready_mode = 0;
    logic        release_flag = 1'b0;
    logic [23:0] exp_q [$];
    logic [23:0] log_q [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic resetCounters();
        xfer_count   = 0;
        done_cnt     = 0;
        aborted_cnt  = 0;
        busy_cycles  = 0;
        stall_cycles = 0;
        stall_cnt    = 0;
        log_q.delete();
    endtask

    // Expected word list for the first n descriptors, straight from the rendering rules
    task automatic buildModel(input int n, output int words, output logic clip);
        int w;
        logic [7:0] mask;
        words = 0;
        clip  = 1'b0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            w    = t_wide[i] ? 16 : 8;
            mask = t_inv[i] ? 8'hFF : 8'h00;
            if (int'(t_x[i]) + w > 128 || t_y[i] == 3'd7) begin
                clip = 1'b1;
            end else begin
                for (int r = 0; r < 2; r++) begin
                    exp_q.push_back({8'h78, 8'h00, 8'hB0 + 8'(int'(t_y[i]) + r)});
                    exp_q.push_back({8'h78, 8'h00, 8'(int'(t_x[i]) % 16)});
                    exp_q.push_back({8'h78, 8'h00, 8'h10 + 8'(int'(t_x[i]) / 16)});
                    for (int c = 0; c < w; c++)
                        exp_q.push_back({8'h78, 8'h40, font(t_code[i], r[0], 4'(c)) ^ mask});
                    words += 3 + w;
                end
            end
        end
    endtask

    // Start a render of n descriptors and wait for it to finish; optionally
    // re-pulse start while busy at iteration extra_start
    task automatic applyStimulus(input int n, input int extra_start, output int exp_words, output logic exp_clip);
        buildModel(n, exp_words, exp_clip);
        resetCounters();
        @(negedge sys_clk);
        num_glyphs = (IDX_W+1)'(n);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 8000 && (done_cnt + aborted_cnt) == 0; cyc++) begin
            start = (cyc == extra_start);
            @(negedge sys_clk);
        end
        start = 1'b0;
        checkOutput("render_finished", 32'((done_cnt + aborted_cnt) > 0), 32'd1);
        repeat (3) @(negedge sys_clk);
        checkOutput("word_count", 32'(xfer_count), 32'(exp_words));
        checkOutput("done_count", 32'(done_cnt), 32'd1);
        checkOutput("aborted_count", 32'(aborted_cnt), 32'd0);
        checkOutput("clip_err", 32'(clip_err), 32'(exp_clip));
        checkOutput("words_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Writer ready generation, updated just after each rising edge
    initial begin
        cmd_if.cmd_ready = 1'b1;
        forever begin
            @(posedge sys_clk);
            #1;
            case (ready_mode)
                1: cmd_if.cmd_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (xfer_count == 3 && stall_cnt < 5) begin
                        cmd_if.cmd_ready = 1'b0;
                        if (cmd_if.cmd_valid) stall_cnt++;
                    end else begin
                        cmd_if.cmd_ready = 1'b1;
                    end
                end
                3: cmd_if.cmd_ready = (xfer_count < 5) || release_flag;
                default: cmd_if.cmd_ready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pop on every accepted word, hold checks while stalled
    initial begin
        logic        prev_stall;
        logic        prev_busy;
        logic [23:0] prev_data;
        logic [10:0] prev_rom;
        prev_stall = 1'b0;
        prev_busy  = 1'b0;
        prev_data  = '0;
        prev_rom   = '0;
        forever begin
            @(negedge sys_clk);
            if (!rst) begin
                if (prev_stall) begin
                    checkOutput("hold_valid", 32'(cmd_if.cmd_valid), 32'd1);
                    checkOutput("hold_data", 32'(cmd_if.cmd_data), 32'(prev_data));
                    checkOutput("hold_rom", 32'({rom_code, rom_row, rom_col}), 32'(prev_rom));
                end
                if (cmd_if.cmd_valid && !cmd_if.cmd_ready) stall_cycles++;
                prev_stall = cmd_if.cmd_valid && !cmd_if.cmd_ready;
                prev_data  = cmd_if.cmd_data;
                prev_rom   = {rom_code, rom_row, rom_col};
                if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                    xfer_count++;
                    log_q.push_back(cmd_if.cmd_data);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_word actual=%0h expected=none", cmd_if.cmd_data);
                    end else begin
                        checkOutput("word", 32'(cmd_if.cmd_data), 32'(exp_q.pop_front()));
                    end
                end
                if (busy) busy_cycles++;
                if (done) begin
                    done_cnt++;
                    checkOutput("done_with_busy_fall", 32'({prev_busy, busy}), 32'h2);
                end
                if (aborted) begin
                    aborted_cnt++;
                    checkOutput("aborted_with_busy_fall", 32'({prev_busy, busy}), 32'h2);
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        int   words;
        logic clp;
        int   waited;
        for (int i = 0; i < 16; i++) begin
            t_code[i] = '0; t_wide[i] = 1'b0; t_inv[i] = 1'b0; t_x[i] = '0; t_y[i] = '0;
        end

        // Reset state
        repeat (3) @(negedge sys_clk);
        checkOutput("reset_cmd_valid", 32'(cmd_if.cmd_valid), 32'd0);
        checkOutput("reset_cmd_data", 32'(cmd_if.cmd_data), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_flags", 32'({done, aborted, clip_err}), 32'd0);
        checkOutput("reset_desc_idx", 32'(desc_idx), 32'd0);
        checkOutput("reset_rom_addr", 32'({rom_code, rom_row, rom_col}), 32'd0);
        rst = 1'b0;
        @(negedge sys_clk);

        // Single narrow glyph at full speed
        $display("[TB] narrow glyph");
        ready_mode = 0;
        t_code[0] = 6'd5; t_wide[0] = 1'b0; t_inv[0] = 1'b0; t_x[0] = 7'd8; t_y[0] = 3'd0;
        applyStimulus(1, -1, words, clp);
        checkOutput("narrow_words", 32'(xfer_count), 32'd22);
        checkOutput("narrow_busy_cycles", 32'(busy_cycles), 32'd40);
        checkOutput("narrow_w0", 32'(log_q[0]), 32'h7800B0);
        checkOutput("narrow_w1", 32'(log_q[1]), 32'h780008);
        checkOutput("narrow_w2", 32'(log_q[2]), 32'h780010);
        checkOutput("narrow_w3_ctrl", 32'(log_q[3][23:8]), 32'h7840);
        checkOutput("narrow_w11", 32'(log_q[11]), 32'h7800B1);

        // Wide inverted glyph, with a start pulse while busy
        $display("[TB] wide inverted glyph");
        t_code[0] = 6'd9; t_wide[0] = 1'b1; t_inv[0] = 1'b1; t_x[0] = 7'd100; t_y[0] = 3'd3;
        applyStimulus(1, 15, words, clp);
        checkOutput("wide_words", 32'(xfer_count), 32'd38);
        checkOutput("wide_w0", 32'(log_q[0]), 32'h7800B3);
        checkOutput("wide_w1", 32'(log_q[1]), 32'h780004);
        checkOutput("wide_w2", 32'(log_q[2]), 32'h780016);
        checkOutput("wide_w19", 32'(log_q[19]), 32'h7800B4);

        // Three glyphs, the middle one clipped off the right edge
        $display("[TB] clipped list");
        t_code[0] = 6'd1; t_wide[0] = 1'b0; t_inv[0] = 1'b0; t_x[0] = 7'd0;   t_y[0] = 3'd1;
        t_code[1] = 6'd2; t_wide[1] = 1'b1; t_inv[1] = 1'b0; t_x[1] = 7'd120; t_y[1] = 3'd2;
        t_code[2] = 6'd3; t_wide[2] = 1'b1; t_inv[2] = 1'b0; t_x[2] = 7'd16;  t_y[2] = 3'd5;
        applyStimulus(3, -1, words, clp);
        checkOutput("clip_words", 32'(xfer_count), 32'd60);
        checkOutput("clip_flag", 32'(clip_err), 32'd1);

        // Writer stalls five cycles on the fourth word
        $display("[TB] stall on fourth word");
        ready_mode = 2;
        t_code[0] = 6'd7; t_wide[0] = 1'b0; t_inv[0] = 1'b0; t_x[0] = 7'd40; t_y[0] = 3'd2;
        applyStimulus(1, -1, words, clp);
        checkOutput("stall_cycles", 32'(stall_cycles), 32'd5);

        // Abort while a data word waits for the writer
        $display("[TB] abort on pending data word");
        t_code[0] = 6'd11; t_wide[0] = 1'b0; t_inv[0] = 1'b1; t_x[0] = 7'd24; t_y[0] = 3'd4;
        buildModel(1, words, clp);
        while (exp_q.size() > 6) void'(exp_q.pop_back());
        resetCounters();
        release_flag = 1'b0;
        ready_mode = 3;
        num_glyphs = 5'd1;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        waited = 0;
        while (!(xfer_count == 5 && cmd_if.cmd_valid && !cmd_if.cmd_ready) && waited < 500) begin
            @(negedge sys_clk);
            waited++;
        end
        checkOutput("abort_setup_reached", 32'(waited < 500), 32'd1);
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        release_flag = 1'b1;
        waited = 0;
        while (aborted_cnt == 0 && waited < 500) begin
            @(negedge sys_clk);
            waited++;
        end
        checkOutput("abort_finished", 32'(aborted_cnt), 32'd1);
        repeat (10) @(negedge sys_clk);
        checkOutput("abort_words", 32'(xfer_count), 32'd6);
        checkOutput("abort_done_count", 32'(done_cnt), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_desc_idx", 32'(desc_idx), 32'd0);
        checkOutput("abort_words_left", 32'(exp_q.size()), 32'd0);
        ready_mode = 0;
        release_flag = 1'b0;

        // Empty list: done two cycles after start, no words
        $display("[TB] empty list");
        exp_q.delete();
        resetCounters();
        num_glyphs = 5'd0;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        checkOutput("empty_cycle1_busy", 32'(busy), 32'd1);
        checkOutput("empty_cycle1_done", 32'(done), 32'd0);
        @(negedge sys_clk);
        checkOutput("empty_cycle2_done", 32'(done), 32'd1);
        checkOutput("empty_cycle2_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge sys_clk);
        checkOutput("empty_words", 32'(xfer_count), 32'd0);

        // Random lists with a random writer
        $display("[TB] random lists");
        ready_mode = 1;
        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                t_code[i] = 6'($urandom_range(0, 63));
                t_wide[i] = 1'($urandom_range(0, 1));
                t_inv[i]  = 1'($urandom_range(0, 1));
                t_x[i]    = 7'($urandom_range(0, 127));
                t_y[i]    = 3'($urandom_range(0, 7));
            end
            applyStimulus(n, -1, words, clp);
        end
        ready_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oled_text_seq.md
# oled_text_seq

Parametrised glyph-string renderer for the SSD1306-class OLED path. On a start pulse it walks a caller-supplied glyph descriptor list and mixes 8x16 and 16x16 glyphs. For each glyph it emits the page/column addressing commands and font bytes as 24-bit IIC words {slave addr, control byte, payload}. It sits between the screen-content logic (descriptor table, font ROM) and the IIC byte writer, handshaking one word at a time. It adds run-time list length, per-glyph inversion, off-screen clipping and abort.

## Interface

- NUM_GLYPHS, 16, maximum descriptors in one list
- IDX_W, 4, width of glyph index (must satisfy 2^IDX_W >= NUM_GLYPHS)
- CODE_W, 6, width of glyph code into font ROM
- OLED_ADDR, 8'h78, IIC slave address byte placed in cmd_data[23:16]
- sys_clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a render when idle, ignored when busy
- abort  in  1  level/pulse; stops the render at the next word boundary
- num_glyphs  in  IDX_W+1  descriptors to render (0..NUM_GLYPHS), sampled on start
- desc_idx  out  IDX_W  descriptor being fetched
- desc_code  in  CODE_W  glyph code for desc_idx (combinational table)
- desc_wide  in  1  1 = 16x16, 0 = 8x16
- desc_inv  in  1  1 = invert all data bytes of the glyph
- desc_x  in  7  start column 0..127
- desc_y  in  3  start page 0..7
- rom_code  out  CODE_W  font ROM glyph select
- rom_row  out  1  0 = upper page, 1 = lower page
- rom_col  out  4  column within glyph 0..15
- rom_data  in  8  font byte, valid exactly 1 cycle after rom_* change
- cmd_valid  out  1  cmd_data holds a word to send
- cmd_data  out  24  IIC word
- cmd_ready  in  1  writer accepts word (transfer = cmd_valid & cmd_ready)
- busy  out  1  render in progress
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse on abort completion
- clip_err  out  1  sticky: at least one glyph skipped; cleared on accepted start

## Operation

- States: IDLE, FETCH, PAGE, COLL, COLH, RDROM, DATA, NEXT.
- IDLE: accepted start latches num_glyphs and sets desc_idx=0, row=0, busy=1, clip_err=0. If num_glyphs=0, go to NEXT, which pulses done with no words. Otherwise go to FETCH.
- FETCH: latch code/wide/inv/x/y.
  - W = 16 if wide, else 8.
  - If x+W > 128 or y = 7, the glyph is clipped: set clip_err, emit no words, go to NEXT.
- PAGE: cmd_data = {OLED_ADDR, 8'h00, 8'hB0 | (y+row)}.
- COLL: cmd_data = {OLED_ADDR, 8'h00, 8'h00 | x[3:0]}.
- COLH: cmd_data = {OLED_ADDR, 8'h00, 8'h10 | x[6:4]}.
- RDROM: drive rom_code/rom_row/rom_col, cmd_valid=0, stay one cycle.
- DATA: cmd_data = {OLED_ADDR, 8'h40, rom_data ^ {8{inv}}}.
  - After transfer, col+1. If col < W-1, go to RDROM.
  - Else if row=0: row=1, col=0, go to PAGE.
  - Else go to NEXT.
- NEXT: row=0, col=0. If desc_idx = num_glyphs-1 (or num_glyphs=0): done pulse, busy=0, go to IDLE. Otherwise desc_idx+1, go to FETCH.
- Words per glyph: 2*(3+W), which is 22 narrow and 38 wide.
- abort:
  - With cmd_valid=0, abort returns to IDLE next cycle.
  - With cmd_valid=1, abort waits for that transfer, then returns to IDLE.
  - No word is ever dropped or changed while valid.
  - Pulses aborted, not done. desc_idx resets to 0.
- abort and start in the same cycle in IDLE: start wins, and abort is ignored.

## Timing

- Reset values: cmd_valid=0, cmd_data=0, busy=0, done=0, aborted=0, clip_err=0, desc_idx=0, rom_code=0, rom_row=0, rom_col=0. State is IDLE.
- start at cycle 0: busy=1 at cycle 1 (FETCH). First cmd_valid (PAGE) at cycle 2.
- cmd_valid rises in the cycle a command state is entered. It holds with cmd_data stable until cmd_ready. The next state is entered the cycle after transfer.
- Data byte: RDROM cycle, then DATA with cmd_valid in the following cycle. Minimum 2 cycles per data word at cmd_ready=1.
- Narrow glyph with cmd_ready tied high: 1 FETCH + 2*(3 + 2*8) + 1 NEXT = 40 cycles.
- done/aborted: registered, one cycle, asserted with busy falling.
- x+row arithmetic: y+row never exceeds 7 because y=7 is clipped.

## Test plan

- num_glyphs=1, desc {code 5, narrow, x=8, y=0}, cmd_ready=1 -> 22 words.
  - First three: 78_00_B0, 78_00_08, 78_00_10. Then 8 data words 78_40_xx.
  - Then 78_00_B1. done once, 40 cycles after start.
- Wide glyph x=100, y=3, inv=1 -> column words 78_00_04 / 78_00_16. 16 data bytes per row, each equal to the ROM byte ^ FF. 38 words total.
- 3-glyph list where glyph 1 has x=120, wide -> clip_err=1. Words emitted only for glyphs 0 and 2. done still pulses.
- cmd_ready held low 5 cycles on the 4th word -> cmd_valid and cmd_data stable throughout. No ROM address change.
- abort raised while a data word is valid and unaccepted -> word completes on cmd_ready. No further words. aborted pulse, busy=0, no done.
- num_glyphs=0 start -> zero words. done 2 cycles after start. start pulsed while busy -> ignored, word sequence unchanged.
